// File: rtl/univ_shift_reg.sv
// ----------------------------------------------------------------------------
// univ_shift_reg
//
// Universal shift register with single-step shift/rotate/load/clear operations
// and a burst engine that repeats a shift or rotate a programmable number of
// times.
//
// Parameters
//   WIDTH  : register width in bits (>= 2)
//   AMT_W  : width of the burst step count
//
// Ports
//   clk     in   clock, all state updates on the rising edge
//   rst_n   in   synchronous active-low reset
//   en      in   clock enable; when low all state holds
//   mode    in   3-bit op: 000 hold, 001 shl, 010 shr, 011 rol, 100 ror,
//                101 load, 110 clear, 111 hold
//   d       in   parallel load data
//   sin     in   serial fill bit for shifts
//   start   in   request a burst of repeated shift/rotate steps
//   amount  in   burst step count
//   q       out  register contents
//   sout_l  out  q[WIDTH-1]
//   sout_r  out  q[0]
//   busy    out  high while a burst is in progress
//   done    out  one-cycle pulse when a burst completes
// ----------------------------------------------------------------------------
module univ_shift_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] ModeHold  = 3'b000;
    localparam logic [2:0] ModeShl   = 3'b001;
    localparam logic [2:0] ModeShr   = 3'b010;
    localparam logic [2:0] ModeRol   = 3'b011;
    localparam logic [2:0] ModeRor   = 3'b100;
    localparam logic [2:0] ModeLoad  = 3'b101;
    localparam logic [2:0] ModeClear = 3'b110;
    localparam logic [2:0] ModeHold2 = 3'b111;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] q_q;
    logic [2:0]       cop_q;
    logic [AMT_W-1:0] cnt_q;
    logic             done_q;
    logic             burst_op;

    // One application of an op to the current register value.
    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] val,
        input logic [WIDTH-1:0] ld,
        input logic             fill
    );
        logic [WIDTH-1:0] res;
        res = val;
        case (op)
            ModeShl:   res = {val[WIDTH-2:0], fill};
            ModeShr:   res = {fill, val[WIDTH-1:1]};
            ModeRol:   res = {val[WIDTH-2:0], val[WIDTH-1]};
            ModeRor:   res = {val[0], val[WIDTH-1:1]};
            ModeLoad:  res = ld;
            ModeClear: res = '0;
            ModeHold, ModeHold2: res = val;
            default:   res = val;
        endcase
        return res;
    endfunction

    // Only shifts and rotates can be repeated as a burst.
    assign burst_op = (mode == ModeShl) || (mode == ModeShr) ||
                      (mode == ModeRol) || (mode == ModeRor);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            q_q     <= '0;
            cop_q   <= ModeHold;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            // done is a pulse: it drops on the edge after it rose, even if en is low,
            // so it can never be stretched into a level.
            done_q <= 1'b0;
            if (en) begin
                case (state_q)
                    StIdle: begin
                        if (start && burst_op) begin
                            cop_q <= mode;
                            cnt_q <= amount;
                            if (amount == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q <= StRun;
                            end
                        end else begin
                            q_q <= apply_op(mode, q_q, d, sin);
                        end
                    end
                    StRun: begin
                        // d is irrelevant here: cop_q is always a shift or rotate.
                        q_q   <= apply_op(cop_q, q_q, d, sin);
                        cnt_q <= cnt_q - AMT_W'(1);
                        if (cnt_q == AMT_W'(1)) begin
                            state_q <= StIdle;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign q      = q_q;
    assign sout_l = q_q[WIDTH-1];
    assign sout_r = q_q[0];
    assign busy   = (state_q == StRun);
    assign done   = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin;
    logic       start;
    logic [3:0] amount;
    logic [7:0] q;
    logic       sout_l;
    logic       sout_r;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    univ_shift_reg #(
        .WIDTH(8),
        .AMT_W(4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .mode   (mode),
        .d      (d),
        .sin    (sin),
        .start  (start),
        .amount (amount),
        .q      (q),
        .sout_l (sout_l),
        .sout_r (sout_r),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] val);
        mode = 3'b101;
        d    = val;
        step();
        chk("load", 32'(q), 32'(val));
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; mode = 3'b000; d = 8'h00;
        sin = 1'b0; start = 1'b0; amount = 4'd0;
        step();
        chk("por_q", 32'(q), 32'h00);
        chk("por_busy", 32'(busy), 32'h0);
        chk("por_done", 32'(done), 32'h0);

        // Reset after a load
        rst_n = 1'b1;
        load(8'hA5);
        rst_n = 1'b0; en = 1'b0;
        step();
        chk("rst_q", 32'(q), 32'h00);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        rst_n = 1'b1; en = 1'b1;

        // Single-step shifts
        load(8'hA5);
        mode = 3'b001; sin = 1'b1;
        step();
        chk("shl", 32'(q), 32'h4B);
        mode = 3'b010; sin = 1'b0;
        step();
        chk("shr", 32'(q), 32'h25);
        chk("sout_r", 32'(sout_r), 32'h1);
        chk("sout_l", 32'(sout_l), 32'h0);

        // Rotates
        load(8'h81);
        mode = 3'b011;
        step();
        chk("rol", 32'(q), 32'h03);
        load(8'h81);
        mode = 3'b100;
        step();
        chk("ror", 32'(q), 32'hC0);

        // Hold (111), enable low, clear
        mode = 3'b111;
        step();
        chk("hold111", 32'(q), 32'hC0);
        mode = 3'b110; en = 1'b0;
        step();
        chk("en_low", 32'(q), 32'hC0);
        en = 1'b1;
        step();
        chk("clear", 32'(q), 32'h00);

        // start with a non-burst mode is ignored: plain load happens
        mode = 3'b101; d = 8'h3C; start = 1'b1; amount = 4'd2;
        step();
        chk("start_ign_q", 32'(q), 32'h3C);
        chk("start_ign_busy", 32'(busy), 32'h0);
        start = 1'b0;

        // Full burst: rol x3 of 01, mode toggled mid-burst
        load(8'h01);
        mode = 3'b011; start = 1'b1; amount = 4'd3;
        step();
        chk("b_start_q", 32'(q), 32'h01);
        chk("b_start_busy", 32'(busy), 32'h1);
        start = 1'b0; mode = 3'b010; amount = 4'd9; d = 8'hFF;
        step();
        chk("b1_q", 32'(q), 32'h02);
        chk("b1_busy", 32'(busy), 32'h1);
        mode = 3'b101; start = 1'b1;
        step();
        chk("b2_q", 32'(q), 32'h04);
        chk("b2_busy", 32'(busy), 32'h1);
        chk("b2_done", 32'(done), 32'h0);
        mode = 3'b110; start = 1'b0;
        step();
        chk("b3_q", 32'(q), 32'h08);
        chk("b3_busy", 32'(busy), 32'h0);
        chk("b3_done", 32'(done), 32'h1);
        mode = 3'b000;
        step();
        chk("b_after_done", 32'(done), 32'h0);
        chk("b_after_q", 32'(q), 32'h08);

        // Burst pause: shl x2 with en low for two cycles
        load(8'h01);
        mode = 3'b001; sin = 1'b0; start = 1'b1; amount = 4'd2;
        step();
        chk("p_start_busy", 32'(busy), 32'h1);
        start = 1'b0;
        step();
        chk("p1_q", 32'(q), 32'h02);
        en = 1'b0;
        step();
        chk("p_hold1_q", 32'(q), 32'h02);
        chk("p_hold1_busy", 32'(busy), 32'h1);
        step();
        chk("p_hold2_q", 32'(q), 32'h02);
        chk("p_hold2_busy", 32'(busy), 32'h1);
        en = 1'b1;
        step();
        chk("p_end_q", 32'(q), 32'h04);
        chk("p_end_busy", 32'(busy), 32'h0);
        chk("p_end_done", 32'(done), 32'h1);
        mode = 3'b000;
        step();
        chk("p_after_done", 32'(done), 32'h0);

        // Zero-length burst
        mode = 3'b011; start = 1'b1; amount = 4'd0;
        step();
        chk("z_q", 32'(q), 32'h04);
        chk("z_busy", 32'(busy), 32'h0);
        chk("z_done", 32'(done), 32'h1);
        start = 1'b0; mode = 3'b000;
        step();
        chk("z_after_done", 32'(done), 32'h0);

        // Amount > WIDTH: rotate wraps, shift saturates to sin
        load(8'h01);
        mode = 3'b011; start = 1'b1; amount = 4'd9;
        step();
        start = 1'b0;
        repeat (8) step();
        chk("wrap_busy_mid", 32'(busy), 32'h1);
        // Start accepted in the same cycle done is high
        mode = 3'b100; start = 1'b1; amount = 4'd1;
        step();
        chk("wrap_q", 32'(q), 32'h02);
        chk("wrap_done", 32'(done), 32'h1);
        step();
        chk("bb_busy", 32'(busy), 32'h1);
        start = 1'b0; mode = 3'b000;
        step();
        chk("bb_q", 32'(q), 32'h01);
        chk("bb_done", 32'(done), 32'h1);

        load(8'hFF);
        mode = 3'b001; sin = 1'b0; start = 1'b1; amount = 4'd10;
        step();
        start = 1'b0;
        repeat (10) step();
        chk("sat_q", 32'(q), 32'h00);
        chk("sat_done", 32'(done), 32'h1);
        mode = 3'b000;

        // Reset mid-burst
        load(8'h01);
        mode = 3'b011; start = 1'b1; amount = 4'd5;
        step();
        start = 1'b0;
        step();
        chk("r_mid_q", 32'(q), 32'h02);
        rst_n = 1'b0;
        step();
        chk("r_q", 32'(q), 32'h00);
        chk("r_busy", 32'(busy), 32'h0);
        chk("r_done", 32'(done), 32'h0);
        rst_n = 1'b1; mode = 3'b000;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("r_no_done", 32'(done), 32'h0);
            chk("r_no_busy", 32'(busy), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
